bitrev_loader: RTL and testbench



---
 rtl/bitrev_loader.sv | 98 +++++++++
 tb/tb_bitrev_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bitrev_loader.sv
// FFT input stage: accepts natural-order complex samples and writes them into the
// ping-pong sample memory at bit-reversed addresses, handing each full bank to the core.
module bitrev_loader #(
    parameter int N            = 8,
    parameter int BITS_PER_ROW = 3,
    parameter int DATA_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_re,
    input  logic [DATA_W-1:0]       in_im,
    input  logic                    fft_busy,
    output logic                    wr_en,
    output logic                    wr_bank,
    output logic [BITS_PER_ROW-1:0] wr_addr,
    output logic [DATA_W-1:0]       wr_re,
    output logic [DATA_W-1:0]       wr_im,
    output logic                    frame_start,
    output logic                    frame_bank,
    output logic [BITS_PER_ROW:0]   sample_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [BITS_PER_ROW-1:0] LAST = BITS_PER_ROW'(N - 1);

    logic [1:0]              state;
    logic                    load_bank;
    logic [BITS_PER_ROW:0]   cnt;
    logic [BITS_PER_ROW-1:0] rev;
    logic                    accept;

    always_comb begin
        rev = '0;
        for (int i = 0; i < BITS_PER_ROW; i++)
            rev[i] = cnt[BITS_PER_ROW-1-i];
    end

    // Ready decodes only the state register, so it never depends on in_valid or fft_busy.
    assign in_ready   = (state == LOAD);
    assign accept     = in_valid & in_ready;
    assign sample_cnt = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            load_bank   <= 1'b0;
            cnt         <= '0;
            wr_en       <= 1'b0;
            wr_bank     <= 1'b0;
            wr_addr     <= '0;
            wr_re       <= '0;
            wr_im       <= '0;
            frame_start <= 1'b0;
            frame_bank  <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    // enable is deliberately ignored here so a started frame always completes.
                    if (accept) begin
                        wr_en   <= 1'b1;
                        wr_bank <= load_bank;
                        wr_addr <= rev;
                        wr_re   <= in_re;
                        wr_im   <= in_im;
                        cnt     <= cnt + 1'b1;
                        if (cnt[BITS_PER_ROW-1:0] == LAST)
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!fft_busy) begin
                        frame_start <= 1'b1;
                        frame_bank  <= load_bank;
                        load_bank   <= ~load_bank;
                        cnt         <= '0;
                        state       <= enable ? LOAD : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitrev_loader.sv
// Directed bench for bitrev_loader: a cycle table for the first frame plus
// hand-written sequences for backpressure, hold, continuous frames, reset and enable.
module tb_bitrev_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, in_valid, fft_busy;
    logic        in_ready;
    logic [15:0] in_re, in_im;
    logic        wr_en, wr_bank, frame_start, frame_bank;
    logic [2:0]  wr_addr;
    logic [15:0] wr_re, wr_im;
    logic [3:0]  sample_cnt;

    int checks = 0;
    int errors = 0;

    bitrev_loader #(.N(8), .BITS_PER_ROW(3), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .fft_busy(fft_busy), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_addr(wr_addr), .wr_re(wr_re), .wr_im(wr_im), .frame_start(frame_start),
        .frame_bank(frame_bank), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en, vld, busy;
        logic [15:0] re;
        logic        rdy, we;
        logic [2:0]  addr;
        logic        bank, fs, fb;
        logic [3:0]  cnt;
    } vec_t;

    vec_t       tbl [11];
    logic [2:0] brv [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] im_of(input logic [15:0] re);
        return re ^ 16'h5a5a;
    endfunction

    task automatic drive(input logic [15:0] re);
        in_re = re;
        in_im = im_of(re);
    endtask

    // Expect a write of sample re to (bank, addr) with the given running count.
    task automatic chk_wr(input string name, input logic bank, input logic [2:0] addr,
                          input logic [15:0] re, input logic [3:0] cnt);
        chk({name, "_we"}, 32'(wr_en), 32'd1);
        chk({name, "_bank"}, 32'(wr_bank), 32'(bank));
        chk({name, "_addr"}, 32'(wr_addr), 32'(addr));
        chk({name, "_re"}, 32'(wr_re), 32'(re));
        chk({name, "_im"}, 32'(wr_im), 32'(im_of(re)));
        chk({name, "_cnt"}, 32'(sample_cnt), 32'(cnt));
        chk({name, "_fs"}, 32'(frame_start), 32'd0);
    endtask

    task automatic chk_handoff(input string name, input logic fb, input logic rdy);
        chk({name, "_fs"}, 32'(frame_start), 32'd1);
        chk({name, "_fb"}, 32'(frame_bank), 32'(fb));
        chk({name, "_we"}, 32'(wr_en), 32'd0);
        chk({name, "_cnt"}, 32'(sample_cnt), 32'd0);
        chk({name, "_rdy"}, 32'(in_ready), 32'(rdy));
    endtask

    initial begin
        logic [15:0] v;
        int          k;

        brv = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
        //            en vld bsy re     rdy we addr bank fs fb cnt
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 16'd1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 4'd2};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 16'd2, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 4'd3};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 16'd3, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 4'd4};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 16'd4, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 4'd5};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 16'd5, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 4'd6};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'd6, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 4'd7};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 16'd7, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 4'd8};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0};

        rst = 1'b1; enable = 1'b0; in_valid = 1'b0; fft_busy = 1'b0; drive(16'd0);
        #12;
        chk("rst_rdy", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(wr_en), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_cnt", 32'(sample_cnt), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Frame 0 from the cycle table: inputs before each edge, outputs after it.
        for (int i = 0; i < 11; i++) begin
            enable = tbl[i].en; in_valid = tbl[i].vld; fft_busy = tbl[i].busy;
            drive(tbl[i].re);
            step();
            chk($sformatf("t%0d_rdy", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("t%0d_we", i), 32'(wr_en), 32'(tbl[i].we));
            chk($sformatf("t%0d_fs", i), 32'(frame_start), 32'(tbl[i].fs));
            chk($sformatf("t%0d_cnt", i), 32'(sample_cnt), 32'(tbl[i].cnt));
            if (tbl[i].we) begin
                chk($sformatf("t%0d_addr", i), 32'(wr_addr), 32'(tbl[i].addr));
                chk($sformatf("t%0d_bank", i), 32'(wr_bank), 32'(tbl[i].bank));
                chk($sformatf("t%0d_re", i), 32'(wr_re), 32'(tbl[i].re));
                chk($sformatf("t%0d_im", i), 32'(wr_im), 32'(im_of(tbl[i].re)));
            end
            if (tbl[i].fs) chk($sformatf("t%0d_fb", i), 32'(frame_bank), 32'(tbl[i].fb));
        end

        // Frame on bank 1 with in_valid toggling; fft_busy high throughout LOAD is ignored.
        fft_busy = 1'b1;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid = (i % 2 == 0);
            drive(16'(16'h100 + k));
            step();
            if (i % 2 == 0) begin
                chk_wr("tog", 1'b1, brv[k], 16'(16'h100 + k), 4'(k + 1));
                k++;
            end else begin
                chk("tog_idle_we", 32'(wr_en), 32'd0);
                chk("tog_idle_cnt", 32'(sample_cnt), 32'(k));
            end
        end
        chk("tog_full_rdy", 32'(in_ready), 32'd0);

        // Core busy: bank stays held, nothing written, no handoff.
        in_valid = 1'b1; drive(16'hdead);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("busy_rdy", 32'(in_ready), 32'd0);
            chk("busy_we", 32'(wr_en), 32'd0);
            chk("busy_fs", 32'(frame_start), 32'd0);
            chk("busy_cnt", 32'(sample_cnt), 32'd8);
        end
        fft_busy = 1'b0;
        step();
        chk_handoff("busy_ho", 1'b1, 1'b1);

        // Three back-to-back frames with in_valid held high.
        v = 16'h200;
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 8; j++) begin
                drive(v);
                step();
                chk_wr($sformatf("cont%0d", f), 1'(f % 2), brv[j], v, 4'(j + 1));
                chk("cont_rdy", 32'(in_ready), 32'(j != 7));
                v++;
            end
            drive(v);
            step();
            chk_handoff($sformatf("cont%0d_ho", f), 1'(f % 2), 1'b1);
        end

        // Abort mid-frame on bank 1 with an asynchronous reset.
        for (int j = 0; j < 5; j++) begin
            drive(16'(16'h300 + j));
            step();
            chk_wr("pre_rst", 1'b1, brv[j], 16'(16'h300 + j), 4'(j + 1));
        end
        #2; rst = 1'b1; #1;
        chk("arst_we", 32'(wr_en), 32'd0);
        chk("arst_rdy", 32'(in_ready), 32'd0);
        chk("arst_addr", 32'(wr_addr), 32'd0);
        chk("arst_re", 32'(wr_re), 32'd0);
        chk("arst_cnt", 32'(sample_cnt), 32'd0);
        chk("arst_bank", 32'(wr_bank), 32'd0);
        @(negedge clk); rst = 1'b0;
        in_valid = 1'b1; drive(16'h400);
        step();
        chk("post_rst_rdy", 32'(in_ready), 32'd1);
        chk("post_rst_we", 32'(wr_en), 32'd0);
        for (int j = 0; j < 8; j++) begin
            drive(16'(16'h400 + j));
            step();
            chk_wr("post_rst", 1'b0, brv[j], 16'(16'h400 + j), 4'(j + 1));
        end
        step();
        chk_handoff("post_rst_ho", 1'b0, 1'b1);

        // Drop enable mid-frame: frame completes, hands off bank 1, then idles.
        for (int j = 0; j < 8; j++) begin
            if (j == 3) enable = 1'b0;
            drive(16'(16'h500 + j));
            step();
            chk_wr("en_drop", 1'b1, brv[j], 16'(16'h500 + j), 4'(j + 1));
        end
        step();
        chk_handoff("en_drop_ho", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_rdy", 32'(in_ready), 32'd0);
            chk("idle_we", 32'(wr_en), 32'd0);
            chk("idle_fs", 32'(frame_start), 32'd0);
        end
        enable = 1'b1;
        step();
        chk("reen_rdy", 32'(in_ready), 32'd1);
        chk("reen_we", 32'(wr_en), 32'd0);
        drive(16'h600);
        step();
        chk_wr("reen", 1'b0, 3'd0, 16'h600, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
